// File: rtl/conc_trace_recorder.sv
// Samples {obs, x_out} each clock, run-length encodes it into an internal trace buffer,
// then drains the records in capture order over a valid/ready port.
module conc_trace_recorder #(
   parameter int DEPTH = 1024,
   parameter int RW    = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [5:0]             x_out,
   input  logic                   obs,
   input  logic                   cap_start,
   input  logic                   cap_stop,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [RW+6:0]          rd_data,
   output logic                   rd_last,
   output logic                   busy,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] rec_count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [RW-1:0]  RMAX     = '1;
   localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DRAIN} state_t;

   state_t          r_state, w_state_nxt;
   logic [6:0]      r_cur, w_cur_nxt;
   logic [RW-1:0]   r_run, w_run_nxt;
   logic [AW:0]     r_wptr, w_wptr_nxt;
   logic [AW:0]     r_rptr, w_rptr_nxt;
   logic            r_overflow, w_overflow_nxt;
   logic            w_we;
   logic [AW-1:0]   w_waddr;
   logic [RW+6:0]   w_wdata;
   logic [6:0]      w_sample;
   logic            w_xfer;
   logic [RW+6:0]   r_mem [DEPTH];

   assign w_sample = {obs, x_out};
   assign w_xfer   = rd_valid & rd_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_nxt      = r_cur;
      w_run_nxt      = r_run;
      w_wptr_nxt     = r_wptr;
      w_rptr_nxt     = r_rptr;
      w_overflow_nxt = r_overflow;
      w_we           = 1'b0;
      w_waddr        = r_wptr[AW-1:0];
      w_wdata        = {r_run, r_cur};
      case (r_state)
         S_IDLE: begin
            if (cap_start) begin
               w_cur_nxt      = w_sample;
               w_run_nxt      = RW'(1);
               w_wptr_nxt     = '0;
               w_rptr_nxt     = '0;
               w_overflow_nxt = 1'b0;
               w_state_nxt    = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (cap_stop) begin
               w_state_nxt = S_FLUSH;
            end else if (w_sample == r_cur && r_run != RMAX) begin
               w_run_nxt = r_run + 1'b1;
            end else begin
               w_we       = 1'b1;
               w_wptr_nxt = r_wptr + 1'b1;
               w_cur_nxt  = w_sample;
               w_run_nxt  = RW'(1);
               // Filling the last slot ends capture; the new pending sample is dropped.
               if (r_wptr == {1'b0, LAST_IDX}) begin
                  w_overflow_nxt = 1'b1;
                  w_state_nxt    = S_DRAIN;
               end
            end
         end
         S_FLUSH: begin
            w_we        = 1'b1;
            w_wptr_nxt  = r_wptr + 1'b1;
            w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_xfer) begin
               w_rptr_nxt = r_rptr + 1'b1;
               if (rd_last) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cur      <= '0;
         r_run      <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur      <= w_cur_nxt;
         r_run      <= w_run_nxt;
         r_wptr     <= w_wptr_nxt;
         r_rptr     <= w_rptr_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   assign rd_valid  = (r_state == S_DRAIN) && (r_rptr < r_wptr);
   assign rd_last   = rd_valid && (r_rptr == r_wptr - 1'b1);
   assign rd_data   = rd_valid ? r_mem[r_rptr[AW-1:0]] : '0;
   assign busy      = (r_state != S_IDLE);
   assign overflow  = r_overflow;
   assign rec_count = r_wptr;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// Drives two recorder instances (large buffer / tiny buffer with 2-bit runs) with shared
// stimulus and compares every drained record against a run-grouping reference model.
module tb_conc_trace_recorder;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  x_out;
   logic        obs;
   logic        cap_start;
   logic        cap_stop;
   logic        rd_ready;

   logic        rd_valid_a, rd_last_a, busy_a, overflow_a;
   logic [14:0] rd_data_a;
   logic [10:0] rec_count_a;
   logic        rd_valid_b, rd_last_b, busy_b, overflow_b;
   logic [8:0]  rd_data_b;
   logic [2:0]  rec_count_b;

   conc_trace_recorder #(.DEPTH(1024), .RW(8)) u_dut_a (
      .clock(clock), .reset(reset), .x_out(x_out), .obs(obs),
      .cap_start(cap_start), .cap_stop(cap_stop),
      .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a), .rd_last(rd_last_a),
      .busy(busy_a), .overflow(overflow_a), .rec_count(rec_count_a)
   );

   conc_trace_recorder #(.DEPTH(4), .RW(2)) u_dut_b (
      .clock(clock), .reset(reset), .x_out(x_out), .obs(obs),
      .cap_start(cap_start), .cap_stop(cap_stop),
      .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b), .rd_last(rd_last_b),
      .busy(busy_b), .overflow(overflow_b), .rec_count(rec_count_b)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];
   bit          ovf_a, ovf_b;
   int          idx_a = 0;
   int          idx_b = 0;
   logic [6:0]  q[$];

   // Group maximal runs of equal samples, split each into RMAX-sized chunks, keep first depth.
   function automatic void build_model(input int depth, input int rmax, input logic [6:0] smp[$],
                                       output logic [31:0] recs[$], output bit ovf);
      int i, j, len, c;
      recs = {};
      i = 0;
      while (i < smp.size()) begin
         j = i;
         while (j < smp.size() && smp[j] == smp[i]) j++;
         len = j - i;
         while (len > 0) begin
            c = (len > rmax) ? rmax : len;
            recs.push_back((32'(c) << 7) | 32'(smp[i]));
            len -= c;
         end
         i = j;
      end
      ovf = (recs.size() > depth);
      while (recs.size() > depth) void'(recs.pop_back());
   endfunction

   always @(negedge clock) begin
      if (reset) begin
         if (rd_valid_a) begin
            if (idx_a < exp_a.size()) begin
               check_eq("rd_data_a", 32'(rd_data_a), exp_a[idx_a]);
               check_eq("rd_last_a", 32'(rd_last_a), 32'(idx_a == exp_a.size() - 1));
            end else check_eq("extra_rec_a", idx_a, exp_a.size());
            if (rd_ready) idx_a++;
         end
         if (rd_valid_b) begin
            if (idx_b < exp_b.size()) begin
               check_eq("rd_data_b", 32'(rd_data_b), exp_b[idx_b]);
               check_eq("rd_last_b", 32'(rd_last_b), 32'(idx_b == exp_b.size() - 1));
            end else check_eq("extra_rec_b", idx_b, exp_b.size());
            if (rd_ready) idx_b++;
         end
      end
   end

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return ($urandom_range(0, 2) != 0);
         default: return (k % 4 == 0) || (k % 4 == 3);
      endcase
   endfunction

   // mode 0: rd_ready high, 1: random, 2: repeating 1,0,0,1
   task automatic run_capture(input logic [6:0] smp[$], input int mode);
      int k = 0;
      int cyc = 0;
      build_model(1024, 255, smp, exp_a, ovf_a);
      build_model(4, 3, smp, exp_b, ovf_b);
      idx_a = 0;
      idx_b = 0;
      cap_start = 1'b1;
      {obs, x_out} = smp[0];
      rd_ready = ready_for(mode, k++);
      @(posedge clock); #1;
      cap_start = 1'b0;
      check_eq("busy_a_rise", 32'(busy_a), 1);
      check_eq("busy_b_rise", 32'(busy_b), 1);
      for (int i = 1; i < smp.size(); i++) begin
         {obs, x_out} = smp[i];
         rd_ready = ready_for(mode, k++);
         @(posedge clock); #1;
      end
      cap_stop = 1'b1;
      {obs, x_out} = 7'($urandom);
      rd_ready = ready_for(mode, k++);
      @(posedge clock); #1;
      cap_stop = 1'b0;
      while ((busy_a || busy_b) && cyc < 4000) begin
         rd_ready = ready_for(mode, k++);
         @(posedge clock); #1;
         cyc++;
      end
      if (cyc >= 4000) check_eq("drain_timeout", cyc, 0);
      rd_ready = 1'b0;
      check_eq("count_a", idx_a, exp_a.size());
      check_eq("count_b", idx_b, exp_b.size());
      check_eq("rec_count_a", 32'(rec_count_a), exp_a.size());
      check_eq("rec_count_b", 32'(rec_count_b), exp_b.size());
      check_eq("overflow_a", 32'(overflow_a), 32'(ovf_a));
      check_eq("overflow_b", 32'(overflow_b), 32'(ovf_b));
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy_a"}, 32'(busy_a), 0);
      check_eq({tag, "_busy_b"}, 32'(busy_b), 0);
      check_eq({tag, "_valid_a"}, 32'(rd_valid_a), 0);
      check_eq({tag, "_valid_b"}, 32'(rd_valid_b), 0);
      check_eq({tag, "_last_a"}, 32'(rd_last_a), 0);
      check_eq({tag, "_data_a"}, 32'(rd_data_a), 0);
      check_eq({tag, "_data_b"}, 32'(rd_data_b), 0);
      check_eq({tag, "_ovf_a"}, 32'(overflow_a), 0);
      check_eq({tag, "_ovf_b"}, 32'(overflow_b), 0);
      check_eq({tag, "_cnt_a"}, 32'(rec_count_a), 0);
      check_eq({tag, "_cnt_b"}, 32'(rec_count_b), 0);
   endtask

   initial begin
      logic [6:0] alph[3];
      int n;
      reset = 1'b0;
      x_out = '0;
      obs = 1'b0;
      cap_start = 1'b0;
      cap_stop = 1'b0;
      rd_ready = 1'b0;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // stray cap_stop in IDLE must be ignored
      cap_stop = 1'b1;
      @(posedge clock); #1;
      cap_stop = 1'b0;
      check_idle_outputs("idle_stop");

      q = {};
      repeat (10) q.push_back(7'h2A);
      run_capture(q, 0);

      q = '{7'h05, 7'h05, 7'h05, 7'h11, 7'h11, 7'h3F};
      run_capture(q, 0);

      q = {};
      repeat (7) q.push_back(7'h09);
      run_capture(q, 0);

      q = {};
      for (int i = 0; i < 8; i++) q.push_back(7'(i * 9 + 3));
      run_capture(q, 0);

      q = '{7'h01, 7'h02, 7'h02, 7'h43, 7'h44, 7'h44, 7'h44};
      run_capture(q, 2);

      q = '{7'h55};
      run_capture(q, 2);

      q = {};
      repeat (300) q.push_back(7'h7E);
      q.push_back(7'h00);
      run_capture(q, 1);

      // reset mid-capture
      cap_start = 1'b1;
      {obs, x_out} = 7'h12;
      @(posedge clock); #1;
      cap_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         {obs, x_out} = 7'(i + 20);
         @(posedge clock); #1;
      end
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(posedge clock); #1;
      reset = 1'b1;
      q = '{7'h21, 7'h21, 7'h60, 7'h60, 7'h60};
      run_capture(q, 1);

      for (int t = 0; t < 25; t++) begin
         for (int a = 0; a < 3; a++) alph[a] = 7'($urandom);
         n = $urandom_range(1, 40);
         q = {};
         for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) != 0) q.push_back(q[i - 1]);
            else q.push_back(alph[$urandom_range(0, 2)]);
         end
         run_capture(q, t % 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conc_trace_recorder.md
# conc_trace_recorder

Output-side companion to the concolic stimulus player. The player streams 8-bit opcodes from memory into the DUT; this block samples the DUT response each clock and writes it back as run-length-encoded trace records into an internal buffer. After capture, a valid/ready port drains the buffer to the bench dump logic. It sits in the generated testbench beside the DUT instance and shares its clock.

## Interface
- DEPTH, 1024: number of trace records held; power of two, at least 4.
- RW, 8: run-length field width; maximum run is RMAX = 2^RW − 1.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- x_out  in  6  DUT output sampled during capture.
- obs  in  1  observation marker sampled alongside x_out.
- cap_start  in  1  start-capture pulse; honoured only in IDLE.
- cap_stop  in  1  stop-capture request; honoured only in CAPTURE.
- rd_valid  out  1  rd_data holds a record.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  RW+7  record {run[RW-1:0], obs, x_out[5:0]}.
- rd_last  out  1  rd_data is the final record.
- busy  out  1  state is not IDLE.
- overflow  out  1  last capture ended because the buffer filled.
- rec_count  out  clog2(DEPTH)+1  records written in the current or last capture.

## Operation
- State machine: IDLE → CAPTURE → FLUSH → DRAIN → IDLE. The FULL exit goes CAPTURE → DRAIN directly.
- Sample s = {obs, x_out}. The pending record is cur (7 bits) plus run (RW bits).
- IDLE with cap_start=1:
  - cur←s, run←1, wptr←0, overflow←0.
  - Go to CAPTURE. The cap_start cycle supplies the first sample.
- CAPTURE with cap_stop=0, for each sample s:
  - If s==cur and run<RMAX: run←run+1.
  - Otherwise: write {run,cur} to mem[wptr], wptr←wptr+1, cur←s, run←1.
  - If that write fills the buffer (wptr was DEPTH−1): overflow←1, go to DRAIN. The new pending sample is discarded.
- CAPTURE with cap_stop=1:
  - The sample in that cycle is not taken.
  - Go to FLUSH.
- cap_start in CAPTURE, and cap_stop outside CAPTURE, are ignored.
- FLUSH: write {run,cur} to mem[wptr], wptr←wptr+1, go to DRAIN. The buffer is never full here, so the write always happens.
- DRAIN:
  - rptr starts at 0.
  - rd_valid=1 while rptr<wptr; rd_data=mem[rptr]; rd_last=(rptr==wptr−1).
  - A transfer occurs when rd_valid&rd_ready; then rptr←rptr+1.
  - The transfer with rd_last=1 returns the block to IDLE.
  - rd_data must stay stable while rd_valid=1 and rd_ready=0.
- rec_count=wptr, and holds its value in IDLE until the next cap_start. overflow also holds until the next cap_start.
- Every capture yields at least one record.
- A run of exactly RMAX identical samples followed by the same value is split: a record with run=RMAX, then a new run starting at 1.

## Timing
- Reset (reset=0) values:
  - state=IDLE, rd_valid=0, rd_last=0, rd_data=0, busy=0, overflow=0, rec_count=0.
  - wptr=rptr=run=cur=0.
  - Memory contents are undefined and need no reset.
- Reset asserted mid-capture or mid-drain aborts immediately. After release the block sits in IDLE with rec_count=0.
- busy rises the cycle after cap_start is accepted.
- Capture produces at most one memory write per cycle.
- The FLUSH write lands one cycle after cap_stop is sampled.
- rd_valid first rises the cycle after DRAIN is entered.
- rd_data is a combinational read of mem[rptr]; zero-latency back-to-back transfers are required, one record per cycle with rd_ready held high.
- After the final transfer, busy falls on the next edge. cap_start is accepted from that IDLE cycle onward.

## Test plan
- Constant capture: x_out=6'h2A, obs=0, cap_start at t0, cap_stop after 10 samples → one record {10,0,2A}; rd_last=1; rec_count=1.
- Changing values: samples 05,05,05,11,11,3F then cap_stop → records {3,05},{2,11},{1,3F}, read in order with rd_ready tied high in three consecutive cycles.
- Run saturation with RW=2: seven identical samples 09, then cap_stop → records {3,09},{3,09},{1,09}.
- Buffer full with DEPTH=4: a value that changes every cycle → exactly 4 records, overflow=1, no FLUSH write, rec_count=4; rd_last on the 4th record.
- Backpressure: toggle rd_ready 1,0,0,1 during drain → rd_data is stable through the stalls; no records are lost or duplicated.
- Reset mid-capture: assert reset=0 after 5 samples → busy=0, rd_valid=0, rec_count=0 in the same cycle. A new cap_start after release captures correctly from wptr=0.
